// File: rtl/watch_set_ctrl.sv
// Time-setting controller for the BCD watch counter chain: freezes counting,
// edits hour/minute/second fields with inc/dec keys, then issues one load strobe.
module watch_set_ctrl #(
    parameter int unsigned BLINK_DIV   = 8,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk_cin,
    input  logic        rst,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic [23:0] cur_time,
    output logic        count_en,
    output logic        load,
    output logic [23:0] preset,
    output logic [1:0]  field_sel,
    output logic        blink,
    output logic        setting
);

    typedef enum logic [2:0] {
        RUN,
        SET_HOUR,
        SET_MIN,
        SET_SEC,
        LOAD
    } state_e;

    state_e           state_q;
    logic [23:0]      edit_q, edit_d;
    logic [23:0]      preset_q;
    logic             count_en_q, load_q, blink_q, setting_q;
    logic [1:0]       field_sel_q;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d, to_cnt_q;
    logic             blink_d, edit_key, timeout;

    // Two-digit BCD step with wrap at maxv in both directions.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv,
                                            input logic up);
        logic [7:0] r;
        if (up) begin
            if (v == maxv)              r = 8'h00;
            else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
            else                        r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)             r = maxv;
            else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
            else                        r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        edit_key = key_inc ^ key_dec;
        timeout  = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        edit_d   = edit_q;
        case (state_q)
            SET_HOUR: edit_d[23:16] = bcd_step(edit_q[23:16], 8'h23, key_inc);
            SET_MIN:  edit_d[15:8]  = bcd_step(edit_q[15:8],  8'h59, key_inc);
            SET_SEC:  edit_d[7:0]   = bcd_step(edit_q[7:0],   8'h59, key_inc);
            default:  edit_d = edit_q;
        endcase
        if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_cin) begin
        if (rst) begin
            state_q     <= RUN;
            edit_q      <= '0;
            preset_q    <= '0;
            count_en_q  <= 1'b1;
            load_q      <= 1'b0;
            field_sel_q <= '0;
            blink_q     <= 1'b0;
            setting_q   <= 1'b0;
            blink_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (key_mode) begin
                        state_q     <= SET_HOUR;
                        edit_q      <= cur_time;
                        count_en_q  <= 1'b0;
                        setting_q   <= 1'b1;
                        field_sel_q <= 2'd1;
                        blink_q     <= 1'b1;
                        blink_cnt_q <= '0;
                        to_cnt_q    <= '0;
                    end
                end
                SET_HOUR, SET_MIN, SET_SEC: begin
                    // mode beats inc/dec; inc+dec together only counts as key activity
                    if (key_mode) begin
                        blink_cnt_q <= '0;
                        to_cnt_q    <= '0;
                        if (state_q == SET_SEC) begin
                            state_q     <= LOAD;
                            preset_q    <= edit_q;
                            load_q      <= 1'b1;
                            field_sel_q <= '0;
                            blink_q     <= 1'b0;
                        end else begin
                            state_q     <= (state_q == SET_HOUR) ? SET_MIN : SET_SEC;
                            field_sel_q <= field_sel_q + 2'd1;
                            blink_q     <= 1'b1;
                        end
                    end else if (key_inc | key_dec) begin
                        to_cnt_q <= '0;
                        if (edit_key) begin
                            edit_q      <= edit_d;
                            blink_q     <= 1'b1;
                            blink_cnt_q <= '0;
                        end else begin
                            blink_q     <= blink_d;
                            blink_cnt_q <= blink_cnt_d;
                        end
                    end else if (timeout) begin
                        state_q     <= RUN;
                        count_en_q  <= 1'b1;
                        setting_q   <= 1'b0;
                        field_sel_q <= '0;
                        blink_q     <= 1'b0;
                        blink_cnt_q <= '0;
                        to_cnt_q    <= '0;
                    end else begin
                        to_cnt_q    <= to_cnt_q + CNT_W'(1);
                        blink_q     <= blink_d;
                        blink_cnt_q <= blink_cnt_d;
                    end
                end
                LOAD: begin
                    state_q    <= RUN;
                    load_q     <= 1'b0;
                    count_en_q <= 1'b1;
                    setting_q  <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign count_en  = count_en_q;
    assign load      = load_q;
    assign preset    = preset_q;
    assign field_sel = field_sel_q;
    assign blink     = blink_q;
    assign setting   = setting_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: a time-arithmetic reference model queues
// expected outputs per cycle and per load strobe; a monitor pops and compares.
module tb_watch_set_ctrl;

    localparam int BLINK_DIV   = 8;
    localparam int TIMEOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        rst, key_mode, key_inc, key_dec;
    logic [23:0] cur_time;
    logic        count_en, load, blink, setting;
    logic [23:0] preset;
    logic [1:0]  field_sel;

    watch_set_ctrl #(
        .BLINK_DIV  (BLINK_DIV),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (16)
    ) dut (
        .clk_cin  (clk),
        .rst      (rst),
        .key_mode (key_mode),
        .key_inc  (key_inc),
        .key_dec  (key_dec),
        .cur_time (cur_time),
        .count_en (count_en),
        .load     (load),
        .preset   (preset),
        .field_sel(field_sel),
        .blink    (blink),
        .setting  (setting)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ce;
        logic        ld;
        logic [1:0]  fs;
        logic        bl;
        logic        st;
        logic [23:0] pre;
    } obs_t;

    obs_t        exp_q[$];
    logic [23:0] load_exp_q[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model: mode 0 run, 1..3 editing hour/min/sec, 4 loading.
    int          md = 0, eh = 0, em = 0, es = 0, idle = 0, phase = 0;
    logic [23:0] m_pre = '0;
    logic [23:0] cur_v = '0;

    function automatic logic [23:0] to_bcd(int h, int m, int s);
        logic [23:0] r;
        r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        return r;
    endfunction

    function automatic logic [23:0] rand_time();
        return to_bcd(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                      int'($urandom_range(0, 59)));
    endfunction

    task automatic model_step(input logic r, input logic km, input logic ki,
                              input logic kd, input logic [23:0] cur);
        if (r) begin
            md = 0; eh = 0; em = 0; es = 0; m_pre = '0; idle = 0; phase = 0;
        end else if (md == 0) begin
            if (km) begin
                md = 1;
                eh = int'(cur[23:20]) * 10 + int'(cur[19:16]);
                em = int'(cur[15:12]) * 10 + int'(cur[11:8]);
                es = int'(cur[7:4]) * 10 + int'(cur[3:0]);
                idle = 0; phase = 0;
            end
        end else if (md == 4) begin
            md = 0;
        end else if (km) begin
            idle = 0; phase = 0;
            if (md == 3) begin
                md    = 4;
                m_pre = to_bcd(eh, em, es);
                load_exp_q.push_back(m_pre);
            end else begin
                md = md + 1;
            end
        end else begin
            if (ki || kd) idle = 0;
            else          idle++;
            if (ki != kd) begin
                phase = 0;
                case (md)
                    1: eh = ki ? (eh + 1) % 24 : (eh + 23) % 24;
                    2: em = ki ? (em + 1) % 60 : (em + 59) % 60;
                    default: es = ki ? (es + 1) % 60 : (es + 59) % 60;
                endcase
            end else begin
                phase++;
            end
            if (idle == TIMEOUT_CYC) md = 0;
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        logic editing;
        editing = (md >= 1 && md <= 3);
        o.ce  = (md == 0);
        o.ld  = (md == 4);
        o.fs  = editing ? 2'(md) : 2'd0;
        o.bl  = editing && (((phase / BLINK_DIV) % 2) == 0);
        o.st  = (md != 0);
        o.pre = m_pre;
        return o;
    endfunction

    task automatic cycle(input logic r, input logic km, input logic ki, input logic kd);
        rst      = r;
        key_mode = km;
        key_inc  = ki;
        key_dec  = kd;
        cur_time = cur_v;
        model_step(r, km, ki, kd, cur_v);
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_preset(input string name, input logic [23:0] want);
        total++;
        if (preset !== want) begin
            bad++;
            $display("FAIL %s: got preset=%h need %h", name, preset, want);
        end
    endtask

    // Monitor
    initial begin
        obs_t        e, a;
        logic [23:0] p;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                a.ce  = count_en;
                a.ld  = load;
                a.fs  = field_sel;
                a.bl  = blink;
                a.st  = setting;
                a.pre = preset;
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t: got ce=%b ld=%b fs=%0d bl=%b st=%b pre=%h need ce=%b ld=%b fs=%0d bl=%b st=%b pre=%h",
                             $time, a.ce, a.ld, a.fs, a.bl, a.st, a.pre,
                             e.ce, e.ld, e.fs, e.bl, e.st, e.pre);
                end
                if (load === 1'b1) begin
                    total++;
                    if (load_exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL load_unexpected @%0t: got load=1 preset=%h need no load", $time, preset);
                    end else begin
                        p = load_exp_q.pop_front();
                        if (preset !== p) begin
                            bad++;
                            $display("FAIL load_preset @%0t: got %h need %h", $time, preset, p);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        cur_v = rand_time();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        idle_n(2);

        // Full set: 12:34:56 -> 15:33:56
        cur_v = 24'h123456;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);
        check_preset("full_set_preset", 24'h153356);

        // Wrap boundaries
        cur_v = 24'h230000;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);
        check_preset("wrap_preset", 24'h231000);

        // Simultaneous keys
        cur_v = 24'h081530;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);
        check_preset("simul_preset", 24'h081530);

        // Reset mid-SET_MIN
        cur_v = rand_time();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        idle_n(3);
        check_preset("reset_preset", 24'h000000);

        // Timeout after an edit leaves preset alone
        cur_v = 24'h071122;
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(2);
        cur_v = rand_time();
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(TIMEOUT_CYC + 6);
        check_preset("timeout_preset", 24'h071122);

        // Blink in SET_SEC, then an edit restarting the period
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(20);
        idle_n(4);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle_n(20);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        idle_n(3);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cur_v = rand_time();
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
        end
        idle_n(TIMEOUT_CYC + 4);

        w = 0;
        @(posedge clk);
        #2;
        while (exp_q.size() > 0 && w < 10) begin
            @(posedge clk);
            #2;
            w++;
        end
        total++;
        if (exp_q.size() != 0 || load_exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending cycles=%0d loads=%0d need 0 and 0",
                     exp_q.size(), load_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
Time-setting controller for the digital watch counter chain (hours/minutes/seconds BCD counters with load/preset/EN inputs). It freezes counting and captures the current time, then steps the user through hour, minute and second fields. Each field is edited with increment/decrement keys. It then issues a single load pulse with all six preset digits and resumes counting. It sits between the debounced key block and the counter chain, and also drives the display blink for the selected field.

Parameters:
BLINK_DIV, 8, clk_cin cycles per blink half-period (≥2).
TIMEOUT_CYC, 64, idle cycles in a set state before abandoning setting without loading (≥2).
CNT_W, 16, width of the internal blink and timeout counters; must hold max(BLINK_DIV, TIMEOUT_CYC).

Ports:
clk_cin  in  1  watch system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
key_mode  in  1  single-cycle pulse: enter setting / advance field
key_inc  in  1  single-cycle pulse: increment selected field
key_dec  in  1  single-cycle pulse: decrement selected field
cur_time  in  24  live BCD time {h_t,h_u,m_t,m_u,s_t,s_u}, 4 bits each
count_en  out  1  EN to counter chain; 0 while setting
load  out  1  one-cycle load strobe to all counters
preset  out  24  preset digits, same packing as cur_time
field_sel  out  2  0 none, 1 hour, 2 min, 3 sec
blink  out  1  display blank gate for the selected field (1 = show)
setting  out  1  1 in any SET state or LOAD

Behaviour:
- Clock and reset: one clock, clk_cin; reset is synchronous and active-high (rst).
- Reset values: state RUN, count_en=1, load=0, preset=0, field_sel=0, blink=0, setting=0, edit register=0, counters=0.
- rst mid-setting abandons the edit with no load pulse.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, LOAD.
- RUN:
  - key_mode → SET_HOUR next cycle.
  - The edit register captures cur_time on the same edge.
  - key_inc and key_dec are ignored.
- SET_HOUR:
  - key_mode → SET_MIN.
  - field_sel=1, count_en=0, setting=1.
- SET_MIN:
  - key_mode → SET_SEC.
  - field_sel=2.
- SET_SEC:
  - key_mode → LOAD.
  - field_sel=3.
- LOAD:
  - Exactly one cycle: load=1, count_en=0, setting=1, field_sel=0.
  - Then RUN: count_en=1, load=0.
- preset:
  - Updates to the edit register on the edge entering LOAD.
  - Holds that value afterwards until the next LOAD.
- Edit arithmetic (BCD, two digits per field, updates on the edge following the key pulse):
  - Hour: inc 23→00, dec 00→23.
  - Minute/second: inc 59→00, dec 00→59.
  - Units digit carries/borrows into the tens digit (09→10, 10→09).
  - Other fields are untouched.
- Simultaneous keys:
  - key_mode wins over inc/dec; the field is not edited in that cycle.
  - key_inc together with key_dec is a no-op.
- Timeout:
  - Counter clears on entry to any SET state and on any key pulse.
  - Increments otherwise.
  - When it reaches TIMEOUT_CYC-1 in a SET state → RUN next cycle, no load, count_en=1.
- Blink:
  - blink=1 and the blink counter clears on every entry into a SET state and on any inc/dec edit.
  - Toggles every BLINK_DIV cycles while in SET states.
  - blink=0 in RUN and LOAD.

Test Plan:
- Reset: assert rst 2 cycles mid-SET_MIN → count_en=1, load=0, field_sel=0, setting=0, preset=0; no load ever seen.
- Full set: cur_time=12:34:56, mode, inc×3, mode, dec×1, mode, mode → one-cycle load with preset=15:33:56, then count_en=1.
- Hour wrap: capture 23:00:00, inc in SET_HOUR → edit hour 00; dec → 23. Minute: 59 inc → 00, 00 dec → 59; 09 inc → 10.
- Simultaneous keys: mode+inc in SET_HOUR → SET_MIN, hour unchanged; inc+dec in SET_MIN → value unchanged.
- Timeout: enter SET_HOUR, inc once, then idle 64 cycles → RUN after exactly 64 idle cycles, load never asserted, preset unchanged from prior value.
- Blink: in SET_SEC with BLINK_DIV=8, blink 1 for 8 cycles, 0 for 8 cycles; inc at cycle 5 forces blink=1 and restarts the period.
